// File: rtl/glyph_to_char.sv
// Bitmap-to-ASCII reverse lookup: linear search over the shared 6x6 font, one glyph per clock.
// Optional INVERT_MATCH_EN also accepts glyphs that match the complemented bitmap.
package glyph_font_pkg;
    // Same table as the display's font_6x6.vh: row-major, bit 35 = row0/col0.
    function automatic logic [35:0] font_lookup(input logic [7:0] ascii);
        logic [35:0] g;
        case (ascii)
            8'h20: g = {6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
            8'h21: g = {6'b001000, 6'b001000, 6'b001000, 6'b000000, 6'b001000, 6'b000000};
            8'h22: g = {6'b010100, 6'b010100, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
            8'h23: g = {6'b010100, 6'b111110, 6'b010100, 6'b111110, 6'b010100, 6'b000000};
            8'h24: g = {6'b011110, 6'b101000, 6'b011100, 6'b001010, 6'b111100, 6'b001000};
            8'h25: g = {6'b110010, 6'b110100, 6'b001000, 6'b010110, 6'b100110, 6'b000000};
            8'h26: g = {6'b011000, 6'b100100, 6'b011010, 6'b100100, 6'b011010, 6'b000000};
            8'h27: g = {6'b001000, 6'b001000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
            8'h28: g = {6'b000100, 6'b001000, 6'b001000, 6'b001000, 6'b000100, 6'b000000};
            8'h29: g = {6'b010000, 6'b001000, 6'b001000, 6'b001000, 6'b010000, 6'b000000};
            8'h2A: g = {6'b101010, 6'b011100, 6'b111110, 6'b011100, 6'b101010, 6'b000000};
            8'h2B: g = {6'b001000, 6'b001000, 6'b111110, 6'b001000, 6'b001000, 6'b000000};
            8'h2C: g = {6'b000000, 6'b000000, 6'b000000, 6'b001000, 6'b001000, 6'b010000};
            8'h2D: g = {6'b000000, 6'b000000, 6'b111110, 6'b000000, 6'b000000, 6'b000000};
            8'h2E: g = {6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001000, 6'b000000};
            8'h2F: g = {6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000, 6'b000000};
            8'h30: g = {6'b011100, 6'b100110, 6'b101010, 6'b110010, 6'b011100, 6'b000000};
            8'h31: g = {6'b001000, 6'b011000, 6'b001000, 6'b001000, 6'b011100, 6'b000000};
            8'h32: g = {6'b011100, 6'b100010, 6'b000100, 6'b011000, 6'b111110, 6'b000000};
            8'h33: g = {6'b111100, 6'b000010, 6'b011100, 6'b000010, 6'b111100, 6'b000000};
            8'h34: g = {6'b000100, 6'b001100, 6'b010100, 6'b111110, 6'b000100, 6'b000000};
            8'h35: g = {6'b111110, 6'b100000, 6'b111100, 6'b000010, 6'b111100, 6'b000000};
            8'h36: g = {6'b011100, 6'b100000, 6'b111100, 6'b100010, 6'b011100, 6'b000000};
            8'h37: g = {6'b111110, 6'b000010, 6'b000100, 6'b001000, 6'b001000, 6'b000000};
            8'h38: g = {6'b011100, 6'b100010, 6'b011100, 6'b100010, 6'b011100, 6'b000000};
            8'h39: g = {6'b011100, 6'b100010, 6'b011110, 6'b000010, 6'b011100, 6'b000000};
            8'h3A: g = {6'b000000, 6'b001000, 6'b000000, 6'b001000, 6'b000000, 6'b000000};
            8'h3B: g = {6'b000000, 6'b001000, 6'b000000, 6'b001000, 6'b010000, 6'b000000};
            8'h3C: g = {6'b000100, 6'b001000, 6'b010000, 6'b001000, 6'b000100, 6'b000000};
            8'h3D: g = {6'b000000, 6'b111110, 6'b000000, 6'b111110, 6'b000000, 6'b000000};
            8'h3E: g = {6'b010000, 6'b001000, 6'b000100, 6'b001000, 6'b010000, 6'b000000};
            8'h3F: g = {6'b011100, 6'b100010, 6'b000100, 6'b000000, 6'b000100, 6'b000000};
            8'h40: g = {6'b011100, 6'b101010, 6'b101110, 6'b100000, 6'b011100, 6'b000000};
            8'h41: g = {6'b011100, 6'b100010, 6'b111110, 6'b100010, 6'b100010, 6'b000000};
            8'h42: g = {6'b111100, 6'b100010, 6'b111100, 6'b100010, 6'b111100, 6'b000000};
            8'h43: g = {6'b011110, 6'b100000, 6'b100000, 6'b100000, 6'b011110, 6'b000000};
            8'h44: g = {6'b111100, 6'b100010, 6'b100010, 6'b100010, 6'b111100, 6'b000000};
            8'h45: g = {6'b111110, 6'b100000, 6'b111100, 6'b100000, 6'b111110, 6'b000000};
            8'h46: g = {6'b111110, 6'b100000, 6'b111100, 6'b100000, 6'b100000, 6'b000000};
            8'h47: g = {6'b011110, 6'b100000, 6'b100110, 6'b100010, 6'b011110, 6'b000000};
            8'h48: g = {6'b100010, 6'b100010, 6'b111110, 6'b100010, 6'b100010, 6'b000000};
            8'h49: g = {6'b011100, 6'b001000, 6'b001000, 6'b001000, 6'b011100, 6'b000000};
            8'h4A: g = {6'b000010, 6'b000010, 6'b000010, 6'b100010, 6'b011100, 6'b000000};
            8'h4B: g = {6'b100100, 6'b101000, 6'b110000, 6'b101000, 6'b100100, 6'b000000};
            8'h4C: g = {6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b111110, 6'b000000};
            8'h4D: g = {6'b100010, 6'b110110, 6'b101010, 6'b100010, 6'b100010, 6'b000000};
            8'h4E: g = {6'b100010, 6'b110010, 6'b101010, 6'b100110, 6'b100010, 6'b000000};
            8'h4F: g = {6'b011100, 6'b100010, 6'b100010, 6'b100010, 6'b011100, 6'b000000};
            8'h50: g = {6'b111100, 6'b100010, 6'b111100, 6'b100000, 6'b100000, 6'b000000};
            8'h51: g = {6'b011100, 6'b100010, 6'b101010, 6'b100100, 6'b011010, 6'b000000};
            8'h52: g = {6'b111100, 6'b100010, 6'b111100, 6'b101000, 6'b100100, 6'b000000};
            8'h53: g = {6'b011110, 6'b100000, 6'b011100, 6'b000010, 6'b111100, 6'b000000};
            8'h54: g = {6'b111110, 6'b001000, 6'b001000, 6'b001000, 6'b001000, 6'b000000};
            8'h55: g = {6'b100010, 6'b100010, 6'b100010, 6'b100010, 6'b011100, 6'b000000};
            8'h56: g = {6'b100010, 6'b100010, 6'b100010, 6'b010100, 6'b001000, 6'b000000};
            8'h57: g = {6'b100010, 6'b100010, 6'b101010, 6'b110110, 6'b100010, 6'b000000};
            8'h58: g = {6'b100010, 6'b010100, 6'b001000, 6'b010100, 6'b100010, 6'b000000};
            8'h59: g = {6'b100010, 6'b010100, 6'b001000, 6'b001000, 6'b001000, 6'b000000};
            8'h5A: g = {6'b111110, 6'b000100, 6'b001000, 6'b010000, 6'b111110, 6'b000000};
            default: g = 36'h0;
        endcase
        return g;
    endfunction
endpackage

module glyph_to_char
    import glyph_font_pkg::*;
#(
    parameter logic [7:0] FIRST_CHAR = 8'h20,
    parameter logic [7:0] LAST_CHAR  = 8'h5A,
    parameter logic [7:0] MISS_CHAR  = 8'h3F
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_img_valid,
    output logic        o_img_ready,
    input  logic [35:0] i_img,
    output logic        o_char_valid,
    input  logic        i_char_ready,
    output logic [7:0]  o_char_out,
    output logic        o_char_found,
    output logic        o_char_inv
);
    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [35:0] r_img_q, w_img_nxt;
    logic [7:0]  r_idx, w_idx_nxt;
    logic [7:0]  r_char, w_char_nxt;
    logic        r_found, w_found_nxt;
    logic        r_inv, w_inv_nxt;
    logic [35:0] w_glyph;
    logic        w_hit, w_hit_inv;

    assign w_glyph = font_lookup(r_idx);
    assign w_hit   = (w_glyph == r_img_q);
`ifdef INVERT_MATCH_EN
    assign w_hit_inv = (w_glyph == ~r_img_q);
`else
    assign w_hit_inv = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_img_q <= 36'h0;
            r_idx   <= FIRST_CHAR;
            r_char  <= 8'h00;
            r_found <= 1'b0;
            r_inv   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_img_q <= w_img_nxt;
            r_idx   <= w_idx_nxt;
            r_char  <= w_char_nxt;
            r_found <= w_found_nxt;
            r_inv   <= w_inv_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_img_nxt   = r_img_q;
        w_idx_nxt   = r_idx;
        w_char_nxt  = r_char;
        w_found_nxt = r_found;
        w_inv_nxt   = r_inv;
        case (r_state)
            S_IDLE: begin
                if (i_img_valid) begin
                    w_img_nxt   = i_img;
                    w_idx_nxt   = FIRST_CHAR;
                    w_state_nxt = S_SEARCH;
                end
            end
            S_SEARCH: begin
                // Normal match outranks an inverted match at the same code.
                if (w_hit || w_hit_inv) begin
                    w_char_nxt  = r_idx;
                    w_found_nxt = 1'b1;
                    w_inv_nxt   = ~w_hit;
                    w_state_nxt = S_DONE;
                end else if (r_idx == LAST_CHAR) begin
                    w_char_nxt  = MISS_CHAR;
                    w_found_nxt = 1'b0;
                    w_inv_nxt   = 1'b0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_nxt = r_idx + 8'd1;
                end
            end
            S_DONE: begin
                if (i_char_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_img_ready  = (r_state == S_IDLE);
    assign o_char_valid = (r_state == S_DONE);
    assign o_char_out   = r_char;
    assign o_char_found = r_found;
    assign o_char_inv   = r_inv;
endmodule

// File: tb/tb_glyph_to_char.sv
// Bench for glyph_to_char: directed decodes checked by a search model every cycle plus literal pins.
module tb_glyph_to_char;
    import glyph_font_pkg::*;

    localparam int FIRST = 32;
    localparam int LAST  = 90;
    localparam int MISS  = 63;
`ifdef INVERT_MATCH_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_img_valid = 1'b0;
    logic        o_img_ready;
    logic [35:0] i_img = 36'h0;
    logic        o_char_valid;
    logic        i_char_ready = 1'b1;
    logic [7:0]  o_char_out;
    logic        o_char_found;
    logic        o_char_inv;

    int n_pass = 0;
    int n_total = 0;

    glyph_to_char dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_img_valid(i_img_valid), .o_img_ready(o_img_ready),
        .i_img(i_img), .o_char_valid(o_char_valid), .i_char_ready(i_char_ready),
        .o_char_out(o_char_out), .o_char_found(o_char_found), .o_char_inv(o_char_inv)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference: scan the font from the lowest code; first exact (or inverted) match wins.
    function automatic void model(input logic [35:0] img, output logic [7:0] c,
                                  output logic f, output logic inv, output int lat);
        c = 8'(MISS); f = 1'b0; inv = 1'b0; lat = LAST - FIRST + 1;
        for (int k = FIRST; k <= LAST; k++) begin
            if (font_lookup(8'(k)) == img || (INV && font_lookup(8'(k)) == ~img)) begin
                c = 8'(k); f = 1'b1; inv = (font_lookup(8'(k)) != img); lat = k - FIRST + 1;
                return;
            end
        end
    endfunction

    logic [7:0] m_char;
    logic       m_found, m_inv;
    int         m_lat;
    bit         trk = 1'b0;
    int         edge_n = 0;

    // Follows the handshakes edge by edge; the model result is taken at acceptance.
    always @(posedge i_clk) begin
        if (i_rst) trk = 1'b0;
        else if (trk) begin
            if (o_char_valid && i_char_ready) trk = 1'b0;
            else edge_n++;
        end else if (o_img_ready && i_img_valid) begin
            model(i_img, m_char, m_found, m_inv, m_lat);
            trk = 1'b1;
            edge_n = 0;
        end
    end

    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (trk) begin
                check("busy_ready", 64'(o_img_ready), 64'(0));
                check("valid_timing", 64'(o_char_valid), 64'(edge_n >= m_lat));
                if (o_char_valid) begin
                    check("m_char", 64'(o_char_out), 64'(m_char));
                    check("m_found", 64'(o_char_found), 64'(m_found));
                    check("m_inv", 64'(o_char_inv), 64'(m_inv));
                end
            end else begin
                check("idle_ready", 64'(o_img_ready), 64'(1));
                check("idle_valid", 64'(o_char_valid), 64'(0));
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    // Decode one bitmap; optionally hold char_ready low, pulse a second image mid-search,
    // or assert reset after rst_at search edges (then returns without waiting for a result).
    task automatic run(input logic [35:0] img, input logic [7:0] lc, input logic lf,
                       input logic li, input int llat, input int hold,
                       input bit pulse, input logic [35:0] pimg, input int rst_at);
        int n;
        logic [7:0] mc; logic mf, mi; int ml;
        model(img, mc, mf, mi, ml);
        check("pin_char", 64'(mc), 64'(lc));
        check("pin_found", 64'(mf), 64'(lf));
        check("pin_inv", 64'(mi), 64'(li));
        check("pin_lat", 64'(ml), 64'(llat));
        n = 0;
        while (!o_img_ready && n < 200) begin step(); n++; end
        i_img = img; i_img_valid = 1'b1; i_char_ready = (hold == 0);
        step();
        i_img_valid = 1'b0; i_img = img ^ 36'h5_A5A5_A5A5;
        n = 0;
        while (!o_char_valid && n < 200) begin
            if (rst_at > 0 && n == rst_at) begin
                i_rst = 1'b1; step(); i_rst = 1'b0;
                check("rst_char", 64'(o_char_out), 64'(0));
                check("rst_found", 64'(o_char_found), 64'(0));
                check("rst_inv", 64'(o_char_inv), 64'(0));
                check("rst_valid", 64'(o_char_valid), 64'(0));
                check("rst_ready", 64'(o_img_ready), 64'(1));
                return;
            end
            if (pulse && n == 3) begin i_img = pimg; i_img_valid = 1'b1; end
            else i_img_valid = 1'b0;
            step(); n++;
        end
        i_img_valid = 1'b0;
        check("lat", 64'(n), 64'(llat));
        check("char", 64'(o_char_out), 64'(lc));
        check("found", 64'(o_char_found), 64'(lf));
        check("inv", 64'(o_char_inv), 64'(li));
        if (hold > 0) begin
            repeat (hold) step();
            check("hold_valid", 64'(o_char_valid), 64'(1));
            check("hold_ready", 64'(o_img_ready), 64'(0));
            check("hold_char", 64'(o_char_out), 64'(lc));
        end
        i_char_ready = 1'b1;
        step();
        check("post_valid", 64'(o_char_valid), 64'(0));
        check("post_ready", 64'(o_img_ready), 64'(1));
    endtask

    initial begin
        step();
        i_rst = 1'b0;
        check("reset_char", 64'(o_char_out), 64'(0));
        check("reset_found", 64'(o_char_found), 64'(0));
        check("reset_valid", 64'(o_char_valid), 64'(0));
        check("reset_ready", 64'(o_img_ready), 64'(1));

        run(font_lookup(8'h41), 8'h41, 1'b1, 1'b0, 34, 0, 1'b0, 36'h0, 0);
        run(36'h0, 8'h20, 1'b1, 1'b0, 1, 0, 1'b0, 36'h0, 0);
        if (INV) run(36'hF_FFFF_FFFF, 8'h20, 1'b1, 1'b1, 1, 0, 1'b0, 36'h0, 0);
        else     run(36'hF_FFFF_FFFF, 8'h3F, 1'b0, 1'b0, 59, 0, 1'b0, 36'h0, 0);
        run(font_lookup(8'h41), 8'h41, 1'b1, 1'b0, 34, 5, 1'b0, 36'h0, 0);
        run(font_lookup(8'h35), 8'h35, 1'b1, 1'b0, 22, 0, 1'b1, font_lookup(8'h21), 0);
        run(font_lookup(8'h3F), 8'h3F, 1'b1, 1'b0, 32, 0, 1'b0, 36'h0, 0);
        run(font_lookup(8'h30), 8'h30, 1'b1, 1'b0, 17, 2, 1'b0, 36'h0, 0);
        run(36'h1_2345_6789, 8'h3F, 1'b0, 1'b0, 59, 0, 1'b0, 36'h0, 0);
        run(font_lookup(8'h4D), 8'h4D, 1'b1, 1'b0, 46, 0, 1'b0, 36'h0, 16);
        run(font_lookup(8'h5A), 8'h5A, 1'b1, 1'b0, 59, 0, 1'b0, 36'h0, 0);
        run(font_lookup(8'h2F), 8'h2F, 1'b1, 1'b0, 16, 1, 1'b0, 36'h0, 0);

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
